regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 91 +++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits and a read-after-issue stall.
// Define RF_BYPASS_EN to forward same-cycle writeback data to the read ports and stall logic.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 RW,
    input  logic [ADDR_W-1:0]    DA,
    input  logic [DATA_W-1:0]    writeData,
    input  logic [ADDR_W-1:0]    SA,
    input  logic [ADDR_W-1:0]    SB,
    output logic [DATA_W-1:0]    readData1,
    output logic [DATA_W-1:0]    readData2,
    input  logic                 issue,
    input  logic [ADDR_W-1:0]    issue_DA,
    output logic                 stall,
    output logic [2**ADDR_W-1:0] pending
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pending;

    logic              w_wrEn;
    logic              w_issueEn;
    logic [DEPTH-1:0]  w_wrMask;
    logic [DEPTH-1:0]  w_issueMask;
    logic [DEPTH-1:0]  w_pendingNext;
    logic [DEPTH-1:0]  w_pendEff;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    assign w_wrEn      = RW && (DA != '0);
    assign w_issueEn   = issue && (issue_DA != '0);
    assign w_wrMask    = w_wrEn    ? (DEPTH'(1) << DA)       : '0;
    assign w_issueMask = w_issueEn ? (DEPTH'(1) << issue_DA) : '0;

    // Set after clear so a new producer issued alongside a writeback keeps the register pending.
    always_comb begin
        w_pendingNext    = (r_pending & ~w_wrMask) | w_issueMask;
        w_pendingNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
        end else begin
            if (w_wrEn) begin
                r_regs[DA] <= writeData;
            end
            r_pending <= w_pendingNext;
        end
    end

`ifdef RF_BYPASS_EN
    // A writeback landing this cycle satisfies its consumer immediately.
    assign w_pendEff = r_pending & ~w_wrMask;

    always_comb begin
        w_rd1 = (SA == '0) ? '0 : r_regs[SA];
        w_rd2 = (SB == '0) ? '0 : r_regs[SB];
        if (w_wrEn && (DA == SA)) begin
            w_rd1 = writeData;
        end
        if (w_wrEn && (DA == SB)) begin
            w_rd2 = writeData;
        end
    end
`else
    assign w_pendEff = r_pending;

    always_comb begin
        w_rd1 = (SA == '0) ? '0 : r_regs[SA];
        w_rd2 = (SB == '0) ? '0 : r_regs[SB];
    end
`endif

    // Gating with reset_n keeps forwarded data off the outputs while reset is held.
    assign readData1 = reset_n ? w_rd1 : '0;
    assign readData2 = reset_n ? w_rd2 : '0;
    assign pending   = r_pending;
    assign stall     = reset_n &&
                       (((SA != '0) && w_pendEff[SA]) || ((SB != '0) && w_pendEff[SB]));

endmodule
